// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: address map shared by the memory responder and its bench.
//   IO_SEL        value of mem_a[17:16] that selects the IO window
//   IO_TX_ADDR    write pushes a byte to the UART TX FIFO; read pops the RX byte
//   IO_CTRL_ADDR  write sets halt; read returns {6'b0, overflow, rx_full}
//   io_decode()   maps an 18-bit address to the IO register it names
package mem_responder_pkg;

  localparam logic [1:0]  IO_SEL       = 2'b11;
  localparam logic [17:0] IO_TX_ADDR   = 18'h30000;
  localparam logic [17:0] IO_CTRL_ADDR = 18'h30004;

  typedef enum logic [1:0] {
    IO_REG_NONE,
    IO_REG_DATA,
    IO_REG_CTRL
  } io_reg_e;

  function automatic io_reg_e io_decode(input logic [17:0] addr);
    if (addr == IO_TX_ADDR)   return IO_REG_DATA;
    if (addr == IO_CTRL_ADDR) return IO_REG_CTRL;
    return IO_REG_NONE;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO with a registered almost-full flag.
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data enqueue request; refused when full unless a pop happens too
//   pop             dequeue request; ignored when empty
//   head            entry at the read pointer
//   count           current occupancy, 0..DEPTH
//   almost_full     registered: free slots after this cycle <= FULL_MARGIN
//   dropped         combinational: this cycle's push was refused
// DEPTH must be a power of two, at least 2, so the pointers wrap for free.
module byte_fifo #(
  parameter  int DEPTH       = 8,
  parameter  int FULL_MARGIN = 2,
  localparam int PW          = $clog2(DEPTH),
  localparam int CW          = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          almost_full,
  output logic          dropped
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;
  assign head    = mem[rd_ptr];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: storage arrays carry no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count       <= count_next;
      almost_full <= (CW'(DEPTH) - count_next) <= CW'(FULL_MARGIN);
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte RAM plus a small UART IO window behind one memory port.
//   clk, rst_n       clock, asynchronous active-low reset
//   mem_a            byte address (bits 17:0 decoded); IO when [17:16] == IO_SEL
//   mem_dout, mem_wr write data / write strobe (0 = read) from the controller
//   mem_din          registered read data, valid the cycle after a read
//   io_buffer_full   TX FIFO nearly full
//   tx_data/valid    TX FIFO head; popped on tx_valid && tx_ready
//   rx_data/valid    incoming UART byte; captured on rx_valid && rx_ready
//   rx_ready         RX holding register empty
//   halt             sticky program-end flag, cleared only by reset
// Every cycle is a transaction: mem_wr=0 is a read, so an idle controller
// should park on a RAM address. RAM contents are not reset and survive rst_n.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halt
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [7:0]        ram [2**ADDR_W];
  logic [ADDR_W-1:0] ram_addr;
  logic              is_io;
  io_reg_e           io_reg;
  logic              ram_wr;
  logic              tx_push;
  logic              tx_pop;
  logic              tx_dropped;
  logic [CW-1:0]     tx_count;
  logic              halt_set;
  logic              rx_take;
  logic              rx_load;
  logic              rx_full;
  logic [7:0]        rx_byte;
  logic              overflow;
  logic [7:0]        rd_data;
  logic              unused_addr_bits;

  assign unused_addr_bits = &{1'b0, mem_a[31:18]};

  assign is_io    = (mem_a[17:16] == IO_SEL);
  assign io_reg   = is_io ? io_decode(mem_a[17:0]) : IO_REG_NONE;
  assign ram_addr = mem_a[ADDR_W-1:0];

  assign ram_wr   = mem_wr && !is_io;
  assign tx_push  = mem_wr && (io_reg == IO_REG_DATA);
  assign halt_set = mem_wr && (io_reg == IO_REG_CTRL);
  assign rx_take  = !mem_wr && (io_reg == IO_REG_DATA);
  assign rx_load  = rx_valid && rx_ready;

  assign rx_ready = !rx_full;
  assign tx_valid = (tx_count != '0);
  assign tx_pop   = tx_valid && tx_ready;

  byte_fifo #(
    .DEPTH       (TX_DEPTH),
    .FULL_MARGIN (FULL_MARGIN)
  ) u_tx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (tx_push),
    .push_data   (mem_dout),
    .pop         (tx_pop),
    .head        (tx_data),
    .count       (tx_count),
    .almost_full (io_buffer_full),
    .dropped     (tx_dropped)
  );

  always_comb begin
    rd_data = 8'h00;
    if (!is_io) begin
      rd_data = ram[ram_addr];
    end else begin
      case (io_reg)
        IO_REG_DATA: rd_data = rx_full ? rx_byte : 8'h00;
        IO_REG_CTRL: rd_data = {6'b0, overflow, rx_full};
        default:     rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) ram[ram_addr] <= mem_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_din  <= 8'h00;
      rx_full  <= 1'b0;
      rx_byte  <= 8'h00;
      overflow <= 1'b0;
      halt     <= 1'b0;
    end else begin
      if (!mem_wr) mem_din <= rd_data;
      // A load can only happen while empty, so a same-cycle read returns 0x00
      // and the freshly loaded byte stays for the next read.
      if (rx_load) begin
        rx_full <= 1'b1;
        rx_byte <= rx_data;
      end else if (rx_take) begin
        rx_full <= 1'b0;
      end
      if (tx_dropped) overflow <= 1'b1;
      if (halt_set)   halt     <= 1'b1;
    end
  end

endmodule
